// File: rtl/ahb_resp_mux_ds.sv
// AHB-Lite master-side response mux with address/data-phase pipeline.
// The address-phase select is registered, and that registered copy steers the
// chosen slave's HRDATA/HREADYOUT/HRESP back to the master in the data phase.
// A built-in default slave returns the two-cycle ERROR for unmapped or
// multi-hot decodes, and a saturating counter tracks those decode errors.

// Per-slave gate: passes the slave's response only when its data-phase select is set.
module ahb_resp_mux_ds_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_ready,
  input  logic                  i_resp,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ready,
  output logic                  o_resp
);
  assign o_rdata = i_sel ? i_rdata : '0;
  assign o_ready = i_sel & i_ready;
  assign o_resp  = i_sel & i_resp;
endmodule

module ahb_resp_mux_ds #(
  parameter int NUM_SLAVES    = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             i_hclk,
  input  logic                             i_hresetn,
  input  logic [NUM_SLAVES-1:0]            i_hsel,
  input  logic [1:0]                       i_htrans,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_shrdata,
  input  logic [NUM_SLAVES-1:0]            i_shreadyout,
  input  logic [NUM_SLAVES-1:0]            i_shresp,
  output logic [DATA_WIDTH-1:0]            o_mhrdata,
  output logic                             o_mhready,
  output logic                             o_mhresp,
  output logic [NUM_SLAVES-1:0]            o_dsel,
  output logic [ERR_CNT_WIDTH-1:0]         o_err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLV  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_SLAVES-1:0]      dsel_q, dsel_d;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] lane_rdata;
  logic [NUM_SLAVES-1:0]                 lane_ready;
  logic [NUM_SLAVES-1:0]                 lane_resp;
  logic [DATA_WIDTH-1:0]                 sel_rdata;
  logic                                  sel_ready;
  logic                                  sel_resp;
  logic                                  hready;
  logic                                  hsel_one_hot;

  // Only HTRANS[1] distinguishes a real transfer (NONSEQ/SEQ) from IDLE/BUSY.
  logic unused_htrans0;
  assign unused_htrans0 = i_htrans[0];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign hsel_one_hot = (i_hsel != '0) &&
                        ((i_hsel & (i_hsel - NUM_SLAVES'(1))) == '0);

  genvar k;
  generate
    for (k = 0; k < NUM_SLAVES; k++) begin : g_lane
      ahb_resp_mux_ds_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .i_sel   (dsel_q[k]),
        .i_rdata (i_shrdata[k*DATA_WIDTH +: DATA_WIDTH]),
        .i_ready (i_shreadyout[k]),
        .i_resp  (i_shresp[k]),
        .o_rdata (lane_rdata[k]),
        .o_ready (lane_ready[k]),
        .o_resp  (lane_resp[k])
      );
    end
  endgenerate

  // AND-OR reduce the gated lanes; dsel_q is one-hot in SLV so at most one contributes.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel_rdata = sel_rdata | lane_rdata[i];
    sel_ready = |lane_ready;
    sel_resp  = |lane_resp;
  end

  // State, data-phase select and error counter registers.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      state_q   <= ST_IDLE;
      dsel_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next state: capture a new address phase on any ready cycle; otherwise hold,
  // except that ERR1 always moves on to ERR2 (where the counter bumps).
  always_comb begin
    state_d   = state_q;
    dsel_d    = dsel_q;
    err_cnt_d = err_cnt_q;
    if (hready) begin
      if (hsel_one_hot) begin
        dsel_d  = i_hsel;
        state_d = i_htrans[1] ? ST_SLV : ST_IDLE;
      end else begin
        dsel_d  = '0;
        state_d = i_htrans[1] ? ST_ERR1 : ST_IDLE;
      end
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  // Master-facing response, purely from state and the registered select.
  always_comb begin
    hready    = 1'b1;
    o_mhresp  = 1'b0;
    o_mhrdata = '0;
    case (state_q)
      ST_SLV: begin
        hready    = sel_ready;
        o_mhresp  = sel_resp;
        o_mhrdata = sel_rdata;
      end
      ST_ERR1: begin
        hready   = 1'b0;
        o_mhresp = 1'b1;
      end
      ST_ERR2: begin
        hready   = 1'b1;
        o_mhresp = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_mhready = hready;
  assign o_dsel    = dsel_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ahb_resp_mux_ds.sv
// Randomised + directed bench for ahb_resp_mux_ds against a transfer-level model.
module tb_ahb_resp_mux_ds;
  localparam int NS = 2;
  localparam int DW = 32;
  localparam int CW = 2;

  logic              i_hclk;
  logic              i_hresetn;
  logic [NS-1:0]     i_hsel;
  logic [1:0]        i_htrans;
  logic [NS*DW-1:0]  i_shrdata;
  logic [NS-1:0]     i_shreadyout;
  logic [NS-1:0]     i_shresp;
  logic [DW-1:0]     o_mhrdata;
  logic              o_mhready;
  logic              o_mhresp;
  logic [NS-1:0]     o_dsel;
  logic [CW-1:0]     o_err_cnt;

  ahb_resp_mux_ds #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
    .i_hclk       (i_hclk),
    .i_hresetn    (i_hresetn),
    .i_hsel       (i_hsel),
    .i_htrans     (i_htrans),
    .i_shrdata    (i_shrdata),
    .i_shreadyout (i_shreadyout),
    .i_shresp     (i_shresp),
    .o_mhrdata    (o_mhrdata),
    .o_mhready    (o_mhready),
    .o_mhresp     (o_mhresp),
    .o_dsel       (o_dsel),
    .o_err_cnt    (o_err_cnt)
  );

  initial i_hclk = 1'b0;
  always #5 i_hclk = ~i_hclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Model: what transfer is in its data phase right now.
  // kind 0 = nothing (zero-wait OKAY), 1 = slave m_idx, 2 = decode error.
  int          m_kind;
  int          m_idx;
  bit          m_err_second;
  logic [1:0]  m_dsel;
  int          m_cnt;

  task automatic model_reset();
    m_kind = 0; m_idx = 0; m_err_second = 0; m_dsel = '0; m_cnt = 0;
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance the model across the edge.
  task automatic cyc(input logic [1:0] hsel, input logic [1:0] htrans,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] rdy, input logic [1:0] rsp);
    logic [31:0] e_data;
    logic        e_rdy, e_rsp;
    logic [31:0] dv [2];
    i_hsel = hsel; i_htrans = htrans; i_shrdata = {d1, d0};
    i_shreadyout = rdy; i_shresp = rsp;
    dv[0] = d0; dv[1] = d1;
    #1;
    case (m_kind)
      1:       begin e_data = dv[m_idx]; e_rdy = rdy[m_idx]; e_rsp = rsp[m_idx]; end
      2:       begin e_data = '0; e_rdy = m_err_second; e_rsp = 1'b1; end
      default: begin e_data = '0; e_rdy = 1'b1; e_rsp = 1'b0; end
    endcase
    chk("hready", o_mhready, e_rdy);
    chk("hresp",  o_mhresp,  e_rsp);
    chk("hrdata", o_mhrdata, e_data);
    chk("dsel",   o_dsel,    m_dsel);
    chk("errcnt", o_err_cnt, m_cnt);
    if (e_rdy) begin
      m_err_second = 0;
      if ($countones(hsel) == 1) begin
        m_dsel = hsel;
        m_idx  = hsel[1] ? 1 : 0;
        m_kind = htrans[1] ? 1 : 0;
      end else begin
        m_dsel = '0;
        m_kind = htrans[1] ? 2 : 0;
      end
    end else if (m_kind == 2 && !m_err_second) begin
      m_err_second = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    @(posedge i_hclk); #1;
  endtask

  initial begin
    logic [1:0] hs;
    int r;
    model_reset();
    i_hresetn = 1'b0;
    i_hsel = '0; i_htrans = 2'b00; i_shrdata = '0; i_shreadyout = '1; i_shresp = '0;
    @(posedge i_hclk); #1;
    chk("rst_ready", o_mhready, 1'b1);
    chk("rst_cnt",   o_err_cnt, 0);
    i_hresetn = 1'b1;

    // Reset mid slave-1 wait state, no clock edge involved.
    cyc(2'b10, 2'b10, 32'h0, 32'h0, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 32'h0, 32'h1234, 2'b01, 2'b00);
    i_shreadyout = 2'b01;
    #1;
    chk("wait_ready", o_mhready, 1'b0);
    #1 i_hresetn = 1'b0;
    #1;
    chk("arst_ready", o_mhready, 1'b1);
    chk("arst_resp",  o_mhresp,  1'b0);
    chk("arst_data",  o_mhrdata, 0);
    chk("arst_dsel",  o_dsel,    0);
    chk("arst_cnt",   o_err_cnt, 0);
    model_reset();
    @(posedge i_hclk); #1;
    i_hresetn = 1'b1;

    // Single read to slave 1, two wait states.
    cyc(2'b10, 2'b10, 32'h0, 32'hDEADBEEF, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 32'h0, 32'hDEADBEEF, 2'b01, 2'b00);
    cyc(2'b00, 2'b00, 32'h0, 32'hDEADBEEF, 2'b01, 2'b00);
    chk("rd_dsel", o_dsel, 2'b10);
    cyc(2'b00, 2'b00, 32'h0, 32'hDEADBEEF, 2'b11, 2'b00);

    // Back-to-back slave0 then slave1, zero wait.
    cyc(2'b01, 2'b10, 32'h0, 32'h0, 2'b11, 2'b00);
    cyc(2'b10, 2'b11, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b11, 2'b00);

    // Unmapped, then multi-hot decode errors.
    cyc(2'b00, 2'b10, 32'h0, 32'h0, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00);
    cyc(2'b11, 2'b10, 32'h0, 32'h0, 2'b11, 2'b00);
    chk("unmap_cnt1", o_err_cnt, 1);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00);
    chk("multi_cnt2", o_err_cnt, 2);

    // IDLE with no select, BUSY to a valid slave: both zero-wait OKAY.
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00);
    cyc(2'b01, 2'b01, 32'h55, 32'h0, 2'b00, 2'b11);
    cyc(2'b00, 2'b00, 32'h55, 32'h0, 2'b00, 2'b11);

    // Slave 0 two-cycle ERROR forwarded verbatim.
    cyc(2'b01, 2'b10, 32'h0, 32'h0, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b10, 2'b01);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b01);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00);

    // Five decode errors saturate the 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      cyc(2'b00, 2'b11, 32'h0, 32'h0, 2'b11, 2'b00);
      cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00);
    end
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 2'b00);
    chk("sat_cnt", o_err_cnt, 3);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      hs = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      cyc(hs, 2'($urandom_range(0, 3)), $urandom, $urandom,
          {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)},
          {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
